// File: rtl/sct_event_fifo.sv
// Capture stage for the control decoder: samples the vector on in_en, detects changed bits,
// and queues timestamped change events in a show-ahead FIFO drained over valid/ready.
module sct_event_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int TS_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_en,
  input  logic             clr_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic [WIDTH-1:0] out_mask,
  output logic [TS_W-1:0]  out_ts,
  output logic [PTR_W:0]   count,
  output logic             overflow
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [TS_W-1:0]  ts_cnt;
  logic [WIDTH-1:0] prev_vec;
  logic             prime;

  logic [WIDTH-1:0] mem_vec  [DEPTH];
  logic [WIDTH-1:0] mem_mask [DEPTH];
  logic [TS_W-1:0]  mem_ts   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             ovf_q;

  logic [WIDTH-1:0] last_vec;
  logic [WIDTH-1:0] last_mask;
  logic [TS_W-1:0]  last_ts;

  logic [WIDTH-1:0] samp_mask;
  logic             evt;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  // The first sample after reset reports every bit as changed so the consumer gets a baseline.
  always_comb begin
    samp_mask = prime ? {WIDTH{1'b1}} : (in_vec ^ prev_vec);
    evt       = in_en && (samp_mask != '0);
    empty     = (count_q == '0);
    full      = (count_q == FULL_COUNT);
    do_pop    = !empty && out_ready;
    do_push   = evt && (!full || do_pop);
    drop      = evt && full && !do_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt   <= '0;
      prev_vec <= '0;
      prime    <= 1'b1;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (in_en) begin
        prev_vec <= in_vec;
        prime    <= 1'b0;
      end
    end
  end

  // Storage needs no reset: pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_vec[wr_ptr]  <= in_vec;
      mem_mask[wr_ptr] <= samp_mask;
      mem_ts[wr_ptr]   <= ts_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      last_vec  <= '0;
      last_mask <= '0;
      last_ts   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        last_vec  <= mem_vec[rd_ptr];
        last_mask <= mem_mask[rd_ptr];
        last_ts   <= mem_ts[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // When empty, the outputs keep showing the most recently popped entry.
  assign out_valid = !empty;
  assign out_vec   = empty ? last_vec  : mem_vec[rd_ptr];
  assign out_mask  = empty ? last_mask : mem_mask[rd_ptr];
  assign out_ts    = empty ? last_ts   : mem_ts[rd_ptr];
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sct_event_fifo.sv
// Directed testbench for sct_event_fifo: inputs driven and outputs checked on the falling edge.
module tb_sct_event_fifo;

  localparam int WIDTH = 15;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int TS_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_vec;
  logic             in_en;
  logic             clr_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_vec;
  logic [WIDTH-1:0] out_mask;
  logic [TS_W-1:0]  out_ts;
  logic [PTR_W:0]   count;
  logic             overflow;

  int compared = 0;
  int mismatched = 0;

  sct_event_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_en(in_en), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .out_mask(out_mask), .out_ts(out_ts), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_en = 1'b0; in_vec = '0; clr_ovf = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic sample(input logic [WIDTH-1:0] v);
    in_en = 1'b1; in_vec = v;
    tick();
    in_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared += 6;
    if (out_valid !== 1'b0) begin $display("[TB] FAIL rst_valid got %h expected 0", out_valid); mismatched++; end
    if (count !== 3'd0) begin $display("[TB] FAIL rst_count got %h expected 0", count); mismatched++; end
    if (overflow !== 1'b0) begin $display("[TB] FAIL rst_ovf got %h expected 0", overflow); mismatched++; end
    if (out_vec !== 15'h0) begin $display("[TB] FAIL rst_vec got %h expected 0", out_vec); mismatched++; end
    if (out_mask !== 15'h0) begin $display("[TB] FAIL rst_mask got %h expected 0", out_mask); mismatched++; end
    if (out_ts !== 8'h0) begin $display("[TB] FAIL rst_ts got %h expected 0", out_ts); mismatched++; end
    tick(); tick(); tick();
    sample(15'h0000);
    compared += 5;
    if (out_valid !== 1'b1) begin $display("[TB] FAIL prime_valid got %h expected 1", out_valid); mismatched++; end
    if (out_mask !== 15'h7FFF) begin $display("[TB] FAIL prime_mask got %h expected 7fff", out_mask); mismatched++; end
    if (out_vec !== 15'h0000) begin $display("[TB] FAIL prime_vec got %h expected 0", out_vec); mismatched++; end
    if (out_ts !== 8'd3) begin $display("[TB] FAIL prime_ts got %h expected 03", out_ts); mismatched++; end
    if (count !== 3'd1) begin $display("[TB] FAIL prime_count got %h expected 1", count); mismatched++; end
  endtask

  task automatic test_change_detect();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    compared += 4;
    if (out_valid !== 1'b0) begin $display("[TB] FAIL pop_valid got %h expected 0", out_valid); mismatched++; end
    if (count !== 3'd0) begin $display("[TB] FAIL pop_count got %h expected 0", count); mismatched++; end
    if (out_mask !== 15'h7FFF) begin $display("[TB] FAIL hold_mask got %h expected 7fff", out_mask); mismatched++; end
    if (out_ts !== 8'd3) begin $display("[TB] FAIL hold_ts got %h expected 03", out_ts); mismatched++; end
    sample(15'h0000);
    compared += 2;
    if (out_valid !== 1'b0) begin $display("[TB] FAIL nochg_valid got %h expected 0", out_valid); mismatched++; end
    if (count !== 3'd0) begin $display("[TB] FAIL nochg_count got %h expected 0", count); mismatched++; end
    sample(15'h0041);
    compared += 4;
    if (out_valid !== 1'b1) begin $display("[TB] FAIL chg_valid got %h expected 1", out_valid); mismatched++; end
    if (out_mask !== 15'h0041) begin $display("[TB] FAIL chg_mask got %h expected 0041", out_mask); mismatched++; end
    if (out_vec !== 15'h0041) begin $display("[TB] FAIL chg_vec got %h expected 0041", out_vec); mismatched++; end
    if (count !== 3'd1) begin $display("[TB] FAIL chg_count got %h expected 1", count); mismatched++; end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    sample(15'h0000);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) sample(WIDTH'(i));
    compared += 2;
    if (count !== 3'd4) begin $display("[TB] FAIL fill_count got %h expected 4", count); mismatched++; end
    if (overflow !== 1'b0) begin $display("[TB] FAIL fill_ovf got %h expected 0", overflow); mismatched++; end
    sample(15'h0005);
    compared += 4;
    if (count !== 3'd4) begin $display("[TB] FAIL drop_count got %h expected 4", count); mismatched++; end
    if (overflow !== 1'b1) begin $display("[TB] FAIL drop_ovf got %h expected 1", overflow); mismatched++; end
    if (out_vec !== 15'h0001) begin $display("[TB] FAIL drop_head_vec got %h expected 0001", out_vec); mismatched++; end
    if (out_mask !== 15'h0001) begin $display("[TB] FAIL drop_head_mask got %h expected 0001", out_mask); mismatched++; end
    sample(15'h0005);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    compared += 1;
    if (count !== 3'd3) begin $display("[TB] FAIL prev_upd_count got %h expected 3", count); mismatched++; end
    sample(15'h0006);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp_vec [5];
    logic [WIDTH-1:0] exp_mask [5];
    exp_vec  = '{15'h3, 15'h4, 15'h6, 15'h7, 15'h0};
    exp_mask = '{15'h1, 15'h7, 15'h3, 15'h1, 15'h0};
    compared += 1;
    if (count !== 3'd4) begin $display("[TB] FAIL b2b_pre_count got %h expected 4", count); mismatched++; end
    out_ready = 1'b1;
    sample(15'h0007);
    compared += 4;
    if (count !== 3'd4) begin $display("[TB] FAIL b2b_count got %h expected 4", count); mismatched++; end
    if (overflow !== 1'b1) begin $display("[TB] FAIL b2b_ovf got %h expected 1", overflow); mismatched++; end
    if (out_vec !== exp_vec[0]) begin $display("[TB] FAIL b2b_vec got %h expected %h", out_vec, exp_vec[0]); mismatched++; end
    if (out_mask !== exp_mask[0]) begin $display("[TB] FAIL b2b_mask got %h expected %h", out_mask, exp_mask[0]); mismatched++; end
    for (int i = 1; i < 4; i++) begin
      tick();
      compared += 2;
      if (out_vec !== exp_vec[i]) begin $display("[TB] FAIL drain_vec[%0d] got %h expected %h", i, out_vec, exp_vec[i]); mismatched++; end
      if (out_mask !== exp_mask[i]) begin $display("[TB] FAIL drain_mask[%0d] got %h expected %h", i, out_mask, exp_mask[i]); mismatched++; end
    end
    tick();
    out_ready = 1'b0;
    compared += 2;
    if (out_valid !== 1'b0) begin $display("[TB] FAIL drain_valid got %h expected 0", out_valid); mismatched++; end
    if (count !== 3'd0) begin $display("[TB] FAIL drain_count got %h expected 0", count); mismatched++; end
  endtask

  task automatic test_clr_ovf();
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    compared += 1;
    if (overflow !== 1'b0) begin $display("[TB] FAIL clr_ovf got %h expected 0", overflow); mismatched++; end
    for (int i = 1; i <= 4; i++) sample(WIDTH'(i * 16));
    clr_ovf = 1'b1;
    sample(15'h0050);
    clr_ovf = 1'b0;
    compared += 2;
    if (overflow !== 1'b1) begin $display("[TB] FAIL clr_vs_drop got %h expected 1", overflow); mismatched++; end
    if (count !== 3'd4) begin $display("[TB] FAIL clr_vs_drop_count got %h expected 4", count); mismatched++; end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) tick();
    sample(15'h0010);
    compared += 2;
    if (out_ts !== 8'd255) begin $display("[TB] FAIL wrap_ts0 got %h expected ff", out_ts); mismatched++; end
    if (out_mask !== 15'h7FFF) begin $display("[TB] FAIL wrap_mask0 got %h expected 7fff", out_mask); mismatched++; end
    sample(15'h0020);
    compared += 1;
    if (count !== 3'd2) begin $display("[TB] FAIL wrap_count got %h expected 2", count); mismatched++; end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    compared += 2;
    if (out_ts !== 8'd0) begin $display("[TB] FAIL wrap_ts1 got %h expected 00", out_ts); mismatched++; end
    if (out_mask !== 15'h0030) begin $display("[TB] FAIL wrap_mask1 got %h expected 0030", out_mask); mismatched++; end
  endtask

  task automatic test_reset_mid();
    sample(15'h0030);
    sample(15'h0040);
    compared += 1;
    if (count !== 3'd3) begin $display("[TB] FAIL mid_pre_count got %h expected 3", count); mismatched++; end
    rst = 1'b1; tick(); rst = 1'b0;
    compared += 2;
    if (count !== 3'd0) begin $display("[TB] FAIL mid_count got %h expected 0", count); mismatched++; end
    if (out_valid !== 1'b0) begin $display("[TB] FAIL mid_valid got %h expected 0", out_valid); mismatched++; end
    sample(15'h0040);
    compared += 3;
    if (out_mask !== 15'h7FFF) begin $display("[TB] FAIL mid_mask got %h expected 7fff", out_mask); mismatched++; end
    if (out_vec !== 15'h0040) begin $display("[TB] FAIL mid_vec got %h expected 0040", out_vec); mismatched++; end
    if (count !== 3'd1) begin $display("[TB] FAIL mid_post_count got %h expected 1", count); mismatched++; end
  endtask

  initial begin
    rst = 1'b1; in_en = 1'b0; in_vec = '0; clr_ovf = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_change_detect();
    test_overflow();
    test_back_to_back();
    test_clr_ovf();
    test_ts_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
